// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encodings used by the decoder and the execute stage.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result, zero flag and illegal-code flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    logic w_slt;

    assign w_slt = $signed(src_a) < $signed(src_b);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_control)
            ALU_ADD: result = src_a + src_b;
            ALU_SUB: result = src_a - src_b;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, w_slt};
            // unsupported codes yield a zero result flagged illegal
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_execute_stage.sv
// ALU execute stage: computes on accept and buffers results in a 2-entry FIFO
// with valid/ready handshakes on both sides.
module alu_execute_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             illegal
);

    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_ill;
    logic             w_push;
    logic             w_pop;

    logic [WIDTH-1:0] r_res [2];
    logic [1:0]       r_zero;
    logic [1:0]       r_ill;
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic [WIDTH-1:0] r_hold_res;
    logic             r_hold_zero;
    logic             r_hold_ill;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .result      (w_res),
        .zero        (w_zero),
        .illegal     (w_ill)
    );

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) r_res[i] <= '0;
            r_zero  <= 2'b11;
            r_ill   <= 2'b00;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else if (flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_res[r_wptr]  <= w_res;
                r_zero[r_wptr] <= w_zero;
                r_ill[r_wptr]  <= w_ill;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Snapshot of the head as shown, so the outputs freeze once the buffer drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_res  <= '0;
            r_hold_zero <= 1'b1;
            r_hold_ill  <= 1'b0;
        end else if (out_valid) begin
            r_hold_res  <= r_res[r_rptr];
            r_hold_zero <= r_zero[r_rptr];
            r_hold_ill  <= r_ill[r_rptr];
        end
    end

    assign alu_result = out_valid ? r_res[r_rptr]  : r_hold_res;
    assign zero       = out_valid ? r_zero[r_rptr] : r_hold_zero;
    assign illegal    = out_valid ? r_ill[r_rptr]  : r_hold_ill;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: directed vectors, expected results queued at accept.
module tb_alu_execute_stage;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         il;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   alu_control = 3'b000;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] alu_result;
    logic         zero;
    logic         illegal;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    alu_execute_stage #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero        (zero),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: head must match the oldest expected entry every cycle it is valid
    always @(negedge clk) begin
        if (!rst && !flush && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: got 0x%08h expected no entry", alu_result);
            end else begin
                chk("head_result", alu_result, exp_q[0].res);
                chk("head_zero", {31'd0, zero}, {31'd0, exp_q[0].z});
                chk("head_illegal", {31'd0, illegal}, {31'd0, exp_q[0].il});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Entered and left at 1 time unit after a rising edge
    task automatic push_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r, input logic z, input logic il);
        int n;
        exp_t e;
        in_valid    = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk);
            #1;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        e.res = r;
        e.z   = z;
        e.il  = il;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        // Reset values while rst is held
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Single add, one-cycle latency
        push_op(3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_result", alu_result, 32'd12);

        // Subtraction wrap and zero; back-to-back exercises push+pop at count 1
        push_op(3'b001, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b0, 1'b0);
        push_op(3'b001, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
        push_op(3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        push_op(3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        idle(3);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure: fill, stall third push, then release
        out_ready = 1'b0;
        push_op(3'b010, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0);
        push_op(3'b011, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        fork
            push_op(3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
            begin
                idle(3);
                chk("stall_hold", alu_result, 32'h30);
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        chk("bp_queue_empty", exp_q.size(), 32'd0);
        chk("empty_hold", alu_result, 32'h2);

        // Illegal code, then flush with a concurrent push at count 2
        out_ready = 1'b0;
        push_op(3'b110, 32'd5, 32'd3, 32'd0, 1'b1, 1'b1);
        chk("ill_result", alu_result, 32'd0);
        chk("ill_zero", {31'd0, zero}, 32'd1);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        push_op(3'b000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
        flush       = 1'b1;
        in_valid    = 1'b1;
        alu_control = 3'b000;
        src_a       = 32'd7;
        src_b       = 32'd7;
        @(negedge clk);
        exp_q.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        idle(3);
        chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream with two buffered entries
        out_ready = 1'b0;
        push_op(3'b000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        push_op(3'b011, 32'h100, 32'h1, 32'h101, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_result", alu_result, 32'd0);
        chk("arst_zero", {31'd0, zero}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        push_op(3'b001, 32'd10, 32'd4, 32'd6, 1'b0, 1'b0);
        chk("post_rst_result", alu_result, 32'd6);
        idle(4);
        chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_hold", alu_result, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_execute_stage.md
ALU_EXECUTE_STAGE -- requirements
Module: alu_execute_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream offers an operation this cycle.
REQ-005 in_ready  output  1  stage can accept an operation this cycle.
REQ-006 alu_control  input  3  operation code from the ALU decoder.
REQ-007 src_a  input  WIDTH  first operand.
REQ-008 src_b  input  WIDTH  second operand.
REQ-009 flush  input  1  synchronous discard of all buffered results.
REQ-010 out_valid  output  1  result entry available at head of buffer.
REQ-011 out_ready  input  1  downstream consumes head entry this cycle.
REQ-012 alu_result  output  WIDTH  result of head entry.
REQ-013 zero  output  1  head entry result equals zero.
REQ-014 illegal  output  1  head entry carried an unsupported alu_control code.

Function
REQ-015 Accept (push) SHALL occur on a rising edge when in_valid && in_ready && !flush.
REQ-016 Pop SHALL occur on a rising edge when out_valid && out_ready && !flush.
REQ-017 Result SHALL be computed combinationally from the accepted inputs and written into a 2-entry FIFO; latency from accept to out_valid = 1 cycle.
REQ-018 Codes: 000 add, 001 sub (src_a - src_b), 010 AND, 011 OR, 101 signed set-less-than (result 1 if $signed(src_a) < $signed(src_b), else 0, zero-extended to WIDTH).
REQ-019 Add/sub SHALL wrap modulo 2^WIDTH; no carry/overflow outputs.
REQ-020 Codes 100, 110, 111 SHALL produce alu_result 0, zero 1, illegal 1; all legal codes produce illegal 0.
REQ-021 zero SHALL equal (alu_result == 0) for every stored entry.
REQ-022 FIFO occupancy count in 0..2; 1-bit write and read pointers wrap 1 -> 0.
REQ-023 in_ready SHALL be (count != 2), combinational from registered state only (no dependency on out_ready).
REQ-024 out_valid SHALL be (count != 0); alu_result/zero/illegal SHALL show the head entry and hold stable while out_valid && !out_ready.
REQ-025 Simultaneous push and pop with count 1 SHALL leave count 1 and deliver entries in acceptance order.
REQ-026 Full (count 2): no push; a pop makes in_ready 1 on the following cycle.
REQ-027 Empty: out_ready ignored; alu_result/zero/illegal hold last values.
REQ-028 flush SHALL set count to 0 and both pointers to 0 on the next edge, discarding any same-cycle push and pop; out_valid 0 the next cycle.

Reset
REQ-029 rst asserted SHALL immediately clear count and pointers; out_valid 0, in_ready 1, alu_result 0, zero 1, illegal 0.
REQ-030 in_valid/out_ready SHALL be ignored while rst is high; reset mid-operation discards all buffered entries.
REQ-031 FIFO data storage SHALL be reset to all-zero (result 0, zero 1, illegal 0).

Structure
REQ-032 Shared package alu_pkg SHALL hold the 3-bit ALUControl encodings (ADD, SUB, AND, OR, SLT) and default WIDTH, also used by the ALU decoder.
REQ-033 Combinational datapath SHALL be sub-module alu_core (inputs alu_control, src_a, src_b; outputs result, zero, illegal); FIFO and handshake stay in alu_execute_stage.

Verification
REQ-034 Reset then push 000, src_a=5, src_b=7, out_ready=1 -> next cycle out_valid 1, alu_result 12, zero 0, illegal 0; popped following edge.
REQ-035 Push 001, 0x00000003 - 0x00000005 -> alu_result 0xFFFFFFFE; push 001, 9-9 -> result 0, zero 1.
REQ-036 Push 101 with src_a=0xFFFFFFFF, src_b=1 -> result 1; src_a=1, src_b=0xFFFFFFFF -> result 0, zero 1.
REQ-037 out_ready=0, push three ops back-to-back (AND 0xF0&0x3C, OR 0xF0|0x0F, ADD 1+1) -> in_ready 0 after second accept; results 0x30 then, after out_ready=1, 0xFF then 0x2 in order, no loss or duplication.
REQ-038 Push code 110 -> alu_result 0, zero 1, illegal 1; then with count 2 assert flush plus in_valid -> next cycle out_valid 0, count 0, flushed push absent.
REQ-039 Assert rst asynchronously mid-stream with count 2 -> out_valid falls before next clock edge; after release first push appears alone.
